// File: rtl/control_pkg.sv
// Shared types, opcode encodings and Moore output decode for the multi-cycle control unit.
package control_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int CLASS_W = 4;

  typedef enum logic [CLASS_W-1:0] {
    CLS_NONE = 4'd0,
    CLS_R    = 4'd1,
    CLS_LW   = 4'd2,
    CLS_SW   = 4'd3,
    CLS_BEQ  = 4'd4,
    CLS_J    = 4'd5,
    CLS_ADDI = 4'd6,
    CLS_MOVE = 4'd7,
    CLS_LB   = 4'd8,
    CLS_SB   = 4'd9
  } iclass_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_MOVE = 6'b010001;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       branch;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       byte_ops;
    logic       move;
    logic       busy;
    logic [1:0] alu_code;
  } ctrl_t;

  function automatic logic is_load(input iclass_t c);
    return (c == CLS_LW) || (c == CLS_LB);
  endfunction

  function automatic logic is_store(input iclass_t c);
    return (c == CLS_SW) || (c == CLS_SB);
  endfunction

  function automatic logic is_byte(input iclass_t c);
    return (c == CLS_LB) || (c == CLS_SB);
  endfunction

  // Input-independent controls for a given state and latched instruction class.
  function automatic ctrl_t moore_ctrl(input state_t st, input iclass_t cls);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.busy     = 1'b1;
        c.mem_read = 1'b1;
        c.alu_code = ALU_ADD;
      end
      DECODE: c.busy = 1'b1;
      EXEC: begin
        c.busy = 1'b1;
        case (cls)
          CLS_R: begin
            c.reg_dst  = 1'b1;
            c.alu_code = ALU_FUNCT;
          end
          CLS_LW, CLS_SW, CLS_LB, CLS_SB, CLS_ADDI: begin
            c.alu_src  = 1'b1;
            c.alu_code = ALU_ADD;
          end
          CLS_BEQ: begin
            c.branch   = 1'b1;
            c.alu_code = ALU_SUB;
          end
          CLS_J:    c.jump = 1'b1;
          CLS_MOVE: c.move = 1'b1;
          default:  c.busy = 1'b1;
        endcase
      end
      MEM: begin
        c.busy      = 1'b1;
        c.mem_read  = is_load(cls);
        c.mem_write = is_store(cls);
        c.byte_ops  = is_byte(cls);
      end
      WB: begin
        c.busy       = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = is_load(cls);
        c.reg_dst    = (cls == CLS_R);
        c.move       = (cls == CLS_MOVE);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode to instruction-class mapping with a legal flag.
// lb/sb are only recognised when BYTE_OPS_EN is defined.
module opcode_decoder
  import control_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CLASS_W-1:0]  iclass,
  output logic                legal
);

  // Map each recognised opcode to its class; anything else is illegal.
  always_comb begin
    iclass = CLS_NONE;
    legal  = 1'b1;
    case (opcode)
      OPCODE_W'(OP_R):    iclass = CLS_R;
      OPCODE_W'(OP_LW):   iclass = CLS_LW;
      OPCODE_W'(OP_SW):   iclass = CLS_SW;
      OPCODE_W'(OP_BEQ):  iclass = CLS_BEQ;
      OPCODE_W'(OP_J):    iclass = CLS_J;
      OPCODE_W'(OP_ADDI): iclass = CLS_ADDI;
      OPCODE_W'(OP_MOVE): iclass = CLS_MOVE;
`ifdef BYTE_OPS_EN
      OPCODE_W'(OP_LB):   iclass = CLS_LB;
      OPCODE_W'(OP_SB):   iclass = CLS_SB;
`endif
      default: begin
        iclass = CLS_NONE;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB with a memory watchdog.
// Define BYTE_OPS_EN to enable lb/sb (handled inside opcode_decoder).
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                regDst,
  output logic                branch,
  output logic                memToReg,
  output logic                ALUsrc,
  output logic                regWrite,
  output logic                jump,
  output logic                byteOperations,
  output logic                move,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                busy,
  output logic                illegal,
  output logic                timeout_err
);

  import control_pkg::*;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  state_t               state_r;
  state_t               next_state_s;
  iclass_t              class_r;
  iclass_t              next_class_s;
  iclass_t              dec_class_s;
  logic [CLASS_W-1:0]   dec_bits_s;
  logic                 dec_legal_s;
  logic [7:0]           wd_cnt_r;
  logic [7:0]           next_wd_cnt_s;
  logic                 wd_expire_s;
  logic                 timeout_err_r;
  ctrl_t                ctrl_r;
  logic                 fetch_done_s;

  opcode_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_opcode_decoder (
    .opcode (opcode),
    .iclass (dec_bits_s),
    .legal  (dec_legal_s)
  );

  assign dec_class_s = iclass_t'(dec_bits_s);

  // The waiting cycle that would make the count reach TIMEOUT is the last one allowed.
  assign wd_expire_s = ({1'b0, wd_cnt_r} + 9'd1) >= TIMEOUT_LIM;

  // Next-state, next-class and watchdog count; the count is zero outside a wait.
  always_comb begin
    next_state_s  = state_r;
    next_class_s  = class_r;
    next_wd_cnt_s = 8'd0;
    case (state_r)
      IDLE: next_state_s = FETCH;
      FETCH: begin
        if (mem_ready) begin
          next_state_s = DECODE;
        end else if (wd_expire_s) begin
          next_state_s = ERR;
        end else begin
          next_state_s  = FETCH;
          next_wd_cnt_s = wd_cnt_r + 8'd1;
        end
      end
      DECODE: begin
        if (dec_legal_s) begin
          next_class_s = dec_class_s;
          next_state_s = EXEC;
        end else begin
          next_class_s = CLS_NONE;
          next_state_s = FETCH;
        end
      end
      EXEC: begin
        case (class_r)
          CLS_R, CLS_ADDI, CLS_MOVE:         next_state_s = WB;
          CLS_LW, CLS_SW, CLS_LB, CLS_SB:    next_state_s = MEM;
          default:                           next_state_s = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (is_load(class_r)) begin
            next_state_s = WB;
          end else begin
            next_state_s = FETCH;
          end
        end else if (wd_expire_s) begin
          next_state_s = ERR;
        end else begin
          next_state_s  = MEM;
          next_wd_cnt_s = wd_cnt_r + 8'd1;
        end
      end
      WB:      next_state_s = FETCH;
      ERR:     next_state_s = ERR;
      default: next_state_s = IDLE;
    endcase
  end

  // State, class, watchdog and the registered Moore controls of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      class_r       <= CLS_NONE;
      wd_cnt_r      <= 8'd0;
      timeout_err_r <= 1'b0;
      ctrl_r        <= '0;
    end else begin
      state_r  <= next_state_s;
      class_r  <= next_class_s;
      wd_cnt_r <= next_wd_cnt_s;
      ctrl_r   <= moore_ctrl(next_state_s, next_class_s);
      if (next_state_s == ERR) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  // Strobes that must react to inputs within the current cycle.
  assign fetch_done_s = (state_r == FETCH) && mem_ready;
  assign irWrite      = fetch_done_s;
  assign pcWrite      = fetch_done_s
                      || ((state_r == EXEC) && (class_r == CLS_J))
                      || ((state_r == EXEC) && (class_r == CLS_BEQ) && zero);
  assign illegal      = (state_r == DECODE) && !dec_legal_s;

  assign memRead        = ctrl_r.mem_read;
  assign memWrite       = ctrl_r.mem_write;
  assign regDst         = ctrl_r.reg_dst;
  assign branch         = ctrl_r.branch;
  assign memToReg       = ctrl_r.mem_to_reg;
  assign ALUsrc         = ctrl_r.alu_src;
  assign regWrite       = ctrl_r.reg_write;
  assign jump           = ctrl_r.jump;
  assign byteOperations = ctrl_r.byte_ops;
  assign move           = ctrl_r.move;
  assign busy           = ctrl_r.busy;
  assign ALUop          = ALUOP_W'(ctrl_r.alu_code);
  assign timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: a per-instruction timeline model builds expected output vectors
// which one compare loop checks against the DUT every cycle.
module tb_multicycle_control_unit;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       memRead, memWrite, irWrite, pcWrite, regDst, branch, memToReg;
  logic       ALUsrc, regWrite, jump, byteOperations, move, busy, illegal, timeout_err;
  logic [2:0] ALUop;

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .pcWrite(pcWrite),
    .regDst(regDst), .branch(branch), .memToReg(memToReg), .ALUsrc(ALUsrc),
    .regWrite(regWrite), .jump(jump), .byteOperations(byteOperations), .move(move),
    .ALUop(ALUop), .busy(busy), .illegal(illegal), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] M_MR   = 18'h00001;
  localparam logic [17:0] M_MW   = 18'h00002;
  localparam logic [17:0] M_IR   = 18'h00004;
  localparam logic [17:0] M_PC   = 18'h00008;
  localparam logic [17:0] M_RD   = 18'h00010;
  localparam logic [17:0] M_BR   = 18'h00020;
  localparam logic [17:0] M_M2R  = 18'h00040;
  localparam logic [17:0] M_SRC  = 18'h00080;
  localparam logic [17:0] M_RW   = 18'h00100;
  localparam logic [17:0] M_J    = 18'h00200;
  localparam logic [17:0] M_BYTE = 18'h00400;
  localparam logic [17:0] M_MOVE = 18'h00800;
  localparam logic [17:0] M_BUSY = 18'h01000;
  localparam logic [17:0] M_ILL  = 18'h02000;
  localparam logic [17:0] M_TERR = 18'h04000;
  localparam logic [17:0] A_SUB  = 18'h08000;
  localparam logic [17:0] A_FUNC = 18'h10000;

  logic [17:0] dut_vec;
  assign dut_vec = {ALUop, timeout_err, illegal, busy, move, byteOperations, jump, regWrite,
                    ALUsrc, memToReg, branch, regDst, pcWrite, irWrite, memWrite, memRead};

  typedef struct {
    string       lbl;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5;
  localparam int K_MOVE = 6, K_LB = 7, K_SB = 8, K_ILL = 9;

  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b001000: return K_ADDI;
      6'b010001: return K_MOVE;
`ifdef BYTE_OPS_EN
      6'b100000: return K_LB;
      6'b101000: return K_SB;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input string l, input logic [5:0] op, input logic z, input logic r,
                      input logic [17:0] e);
    ent_t x;
    x.lbl = l; x.op = op; x.z = z; x.rdy = r; x.exp = e;
    q.push_back(x);
  endtask

  function automatic logic [5:0] junk_op();
    return 6'($urandom);
  endfunction

  function automatic logic junk_bit();
    return 1'($urandom);
  endfunction

  task automatic add_idle();
    push("idle", junk_op(), junk_bit(), junk_bit(), 18'h0);
  endtask

  task automatic add_err(input int n);
    for (int i = 0; i < n; i++) push("err", junk_op(), junk_bit(), junk_bit(), M_TERR);
  endtask

  // Timeline of one instruction; fw/mw are wait cycles, >= TO means the memory never answers.
  task automatic add_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    int k;
    logic ld, st, by;
    logic [17:0] e;
    k  = kind_of(op);
    ld = (k == K_LW) || (k == K_LB);
    st = (k == K_SW) || (k == K_SB);
    by = (k == K_LB) || (k == K_SB);
    for (int i = 0; i < ((fw < TO) ? fw : TO); i++)
      push("fetch_wait", junk_op(), junk_bit(), 1'b0, M_MR | M_BUSY);
    if (fw >= TO) begin
      add_err(3);
      return;
    end
    push("fetch", junk_op(), junk_bit(), 1'b1, M_MR | M_IR | M_PC | M_BUSY);
    push("decode", op, junk_bit(), junk_bit(), M_BUSY | ((k == K_ILL) ? M_ILL : 18'h0));
    if (k == K_ILL) return;
    case (k)
      K_R:    e = M_BUSY | M_RD | A_FUNC;
      K_BEQ:  e = M_BUSY | M_BR | A_SUB | (z ? M_PC : 18'h0);
      K_J:    e = M_BUSY | M_J | M_PC;
      K_MOVE: e = M_BUSY | M_MOVE;
      default: e = M_BUSY | M_SRC;
    endcase
    push("exec", junk_op(), z, junk_bit(), e);
    if (ld || st) begin
      e = M_BUSY | (ld ? M_MR : M_MW) | (by ? M_BYTE : 18'h0);
      for (int i = 0; i < ((mw < TO) ? mw : TO); i++)
        push("mem_wait", junk_op(), junk_bit(), 1'b0, e);
      if (mw >= TO) begin
        add_err(3);
        return;
      end
      push("mem", junk_op(), junk_bit(), 1'b1, e);
    end
    if (k == K_R || k == K_ADDI || k == K_MOVE || ld) begin
      e = M_BUSY | M_RW | (ld ? M_M2R : 18'h0) | ((k == K_R) ? M_RD : 18'h0)
        | ((k == K_MOVE) ? M_MOVE : 18'h0);
      push("wb", junk_op(), junk_bit(), junk_bit(), e);
    end
  endtask

  // The single compare loop: drive just after posedge, compare at negedge.
  task automatic run_queue(output int busy_cycles);
    ent_t x;
    busy_cycles = 0;
    while (q.size() > 0) begin
      x = q.pop_front();
      opcode = x.op; zero = x.z; mem_ready = x.rdy;
      @(negedge clk);
      check(x.lbl, dut_vec, x.exp);
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_assert", dut_vec, 18'h0);
    @(posedge clk);
    #1;
    check("reset_hold", dut_vec, 18'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("reset_initial", dut_vec, 18'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_ready_hi", dut_vec, 18'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Enter FETCH, stall two cycles, then reset mid-FETCH.
    add_idle();
    push("fetch_wait", junk_op(), 1'b0, 1'b0, M_MR | M_BUSY);
    push("fetch_wait", junk_op(), 1'b0, 1'b0, M_MR | M_BUSY);
    run_queue(n);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midfetch", dut_vec, 18'h0);
    mem_ready = 1'b1;
    #1;
    check("reset_midfetch_rdy", dut_vec, 18'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    add_idle();
    add_instr(6'b000000, 1'b0, 0, 0);
    run_queue(n);
    check_int("cpi_R", n, 4);

    add_instr(6'b100011, 1'b0, 0, 3);
    run_queue(n);
    check_int("cpi_lw_3wait", n, 8);

    add_instr(6'b000100, 1'b1, 0, 0);
    run_queue(n);
    check_int("cpi_beq_taken", n, 3);

    add_instr(6'b000100, 1'b0, 0, 0);
    run_queue(n);
    check_int("cpi_beq_not", n, 3);

    add_instr(6'b111111, 1'b0, 0, 0);
    run_queue(n);
    check_int("cpi_illegal", n, 2);

    add_instr(6'b100000, 1'b0, 0, 0);
    run_queue(n);
`ifdef BYTE_OPS_EN
    check_int("cpi_lb", n, 5);
`else
    check_int("cpi_lb_illegal", n, 2);
`endif

    add_instr(6'b101011, 1'b0, 0, 0);
    add_instr(6'b000010, 1'b0, 0, 0);
    add_instr(6'b001000, 1'b0, 2, 0);
    add_instr(6'b010001, 1'b1, 0, 0);
    add_instr(6'b101000, 1'b0, 1, 1);
    add_instr(6'b101011, 1'b1, 0, 2);
    add_instr(6'b000000, 1'b1, 1, 0);
    run_queue(n);

    // Memory answers on the last allowed cycle in FETCH and in MEM.
    add_instr(6'b001000, 1'b0, TO - 1, 0);
    add_instr(6'b100011, 1'b0, 0, TO - 1);
    run_queue(n);
    check_int("cpi_edge", n, 37);

    add_instr(6'b000000, 1'b0, TO, 0);
    run_queue(n);
    check_int("cpi_fetch_timeout", n, TO);

    do_reset();
    add_idle();
    add_instr(6'b101011, 1'b0, 0, TO);
    run_queue(n);
    check_int("cpi_mem_timeout", n, 3 + TO);

    do_reset();
    add_idle();
    add_instr(6'b000010, 1'b0, 0, 0);
    run_queue(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
